sqrt_fp_front: RTL and testbench

SQRT_FP_FRONT -- requirements
Module: sqrt_fp_front

---
 rtl/sqrt_fp_front.sv | 125 ++++++++++++
 tb/tb_sqrt_fp_front.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_fp_front.sv
// Single-precision square-root front end: classifies the operand, builds the integer radicand
// for an external integer sqrt unit and packs its root back into IEEE-754. Macro: SQRT_FP_DENORM_EN.
//
// state  | meaning
// IDLE   | waiting for start; operand latched and classified on the accepting edge
// LAUNCH | sq_start high, radicand presented on sq_num
// WAIT   | radicand held, waiting for sq_ready
// DONE   | ready high, fp_out freshly written
module sqrt_fp_front (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] fp_in,
    output logic        sq_start,
    output logic [31:0] sq_num,
    input  logic        sq_ready,
    input  logic [31:0] sq_out,
    output logic        busy,
    output logic        ready,
    output logic [31:0] fp_out
);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] PINF = 32'h7F80_0000;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;
    state_t state, state_nxt;

    logic              sign;
    logic [7:0]        exp_f;
    logic [22:0]       frac;
    logic              is_special;
    logic [31:0]       special_val;
    logic [23:0]       mant;
    logic signed [8:0] exp_unb;
    logic signed [8:0] exp_half;
    logic [31:0]       radicand;
    logic [7:0]        res_exp_nxt;
    logic [7:0]        res_exp;
    logic              sq_out_unused;

    assign {sign, exp_f, frac} = fp_in;
    assign sq_out_unused = ^sq_out[31:15];

`ifdef SQRT_FP_DENORM_EN
    logic [4:0] lz;

    always_comb begin
        lz = 5'd0;
        for (int i = 0; i < 23; i++)
            if (frac[i]) lz = 5'(22 - i);
    end
`endif

    always_comb begin
        is_special  = 1'b1;
        special_val = QNAN;
        mant        = {1'b1, frac};
        exp_unb     = $signed({1'b0, exp_f}) - 9'sd127;
        if (exp_f == 8'hFF)
            special_val = (|frac || sign) ? QNAN : PINF;
        else if (exp_f == 8'h00 && !(|frac))
            special_val = fp_in;
        else if (sign)
            special_val = QNAN;
        else if (exp_f == 8'h00) begin
`ifdef SQRT_FP_DENORM_EN
            is_special = 1'b0;
            mant       = {frac, 1'b0} << lz;
            exp_unb    = -9'sd127 - $signed({4'b0, lz});
`else
            special_val = {sign, 31'h0};
`endif
        end else
            is_special = 1'b0;
    end

    // Odd exponents take one extra shift so the halved exponent stays exact.
    assign radicand    = exp_unb[0] ? {mant, 8'h00} : {1'b0, mant, 7'h00};
    assign exp_half    = exp_unb >>> 1;
    assign res_exp_nxt = 8'(exp_half + 9'sd127);

    always_comb begin
        state_nxt = state;
        sq_start  = 1'b0;
        ready     = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = is_special ? DONE : LAUNCH;
            end
            LAUNCH: begin
                sq_start  = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: if (sq_ready) state_nxt = DONE;
            DONE: begin
                ready     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            sq_num  <= '0;
            res_exp <= '0;
            fp_out  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                if (is_special)
                    fp_out <= special_val;
                else begin
                    sq_num  <= radicand;
                    res_exp <= res_exp_nxt;
                end
            end
            if (state == WAIT && sq_ready)
                fp_out <= {1'b0, res_exp, sq_out[14:0], 8'h00};
        end
    end
endmodule

// File: tb/tb_sqrt_fp_front.sv
// Randomized bench for sqrt_fp_front with a real-arithmetic reference model and an integer sqrt responder.
module tb_sqrt_fp_front;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] fp_in = '0;
    logic        sq_start;
    logic [31:0] sq_num;
    logic        sq_ready = 1'b0;
    logic [31:0] sq_out = '0;
    logic        busy;
    logic        ready;
    logic [31:0] fp_out;

    int checks = 0;
    int failures = 0;

    logic        exp_busy = 1'b0, exp_ready = 1'b0, exp_sq_start = 1'b0, exp_num_chk = 1'b0;
    logic [31:0] exp_num = '0, exp_fp = '0;
    bit          cmp_en = 1'b0;

    sqrt_fp_front dut (
        .clk(clk), .rst(rst), .start(start), .fp_in(fp_in),
        .sq_start(sq_start), .sq_num(sq_num), .sq_ready(sq_ready), .sq_out(sq_out),
        .busy(busy), .ready(ready), .fp_out(fp_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", 32'(busy), 32'(exp_busy));
            check("ready", 32'(ready), 32'(exp_ready));
            check("sq_start", 32'(sq_start), 32'(exp_sq_start));
            check("fp_out", fp_out, exp_fp);
            if (exp_num_chk) check("sq_num", sq_num, exp_num);
            check("ready_with_sq_start", 32'(ready & sq_start), 32'd0);
        end
    end

    function automatic real pow2(input int e);
        real p = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) p = p * 2.0;
        else        for (int i = 0; i < -e; i++) p = p / 2.0;
        return p;
    endfunction

    function automatic void norm(input real v, output real t, output int e);
        t = v;
        e = 0;
        while (t >= 2.0) begin t = t / 2.0; e++; end
        while (t < 1.0)  begin t = t * 2.0; e--; end
    endfunction

    // Reference: value of the float, exact real sqrt, truncated to 16 significant bits.
    function automatic void model(input logic [31:0] x, output bit special,
                                  output logic [31:0] rad, output logic [31:0] res);
        logic s;
        logic [7:0] ex;
        logic [22:0] fr;
        real v, t, st;
        int e, es;
        longint m, r;
        s = x[31]; ex = x[30:23]; fr = x[22:0];
        special = 1'b1;
        rad = '0;
        res = 32'h7FC00000;
        if (ex == 8'hFF) begin
            if (fr == 23'd0 && !s) res = 32'h7F800000;
        end else if (ex == 8'h00 && fr == 23'd0)
            res = x;
        else if (s)
            res = 32'h7FC00000;
`ifndef SQRT_FP_DENORM_EN
        else if (ex == 8'h00)
            res = 32'h00000000;
`endif
        else begin
            special = 1'b0;
            if (ex == 8'h00) v = real'(fr) * pow2(-149);
            else             v = (8388608.0 + real'(fr)) * pow2(int'(ex) - 150);
            norm(v, t, e);
            m = longint'($floor(t * 8388608.0));
            rad = (e % 2 != 0) ? 32'(m << 8) : 32'(m << 7);
            norm($sqrt(v), st, es);
            r = longint'($floor(st * 32768.0));
            res = {1'b0, 8'(es + 127), 15'(r), 8'h00};
        end
    endfunction

    function automatic logic [15:0] isqrt(input logic [31:0] n);
        return 16'(longint'($floor($sqrt(real'(n)))));
    endfunction

    function automatic logic [31:0] rand_operand();
        int k;
        logic [31:0] x;
        k = $urandom_range(0, 9);
        x = $urandom();
        if (k <= 5) begin
            x[31] = 1'b0;
            x[30:23] = 8'($urandom_range(1, 254));
        end else if (k == 6) begin
            case ($urandom_range(0, 5))
                0: begin x[30:23] = 8'hFF; x[0] = 1'b1; end
                1: x = 32'h7F800000;
                2: x = 32'hFF800000;
                3: x = 32'h00000000;
                4: x = 32'h80000000;
                default: begin x[31] = 1'b1; x[30:23] = 8'($urandom_range(1, 254)); end
            endcase
        end else if (k == 7 || k == 8) begin
            x[31] = (k == 8);
            x[30:23] = 8'h00;
            if (x[22:0] == 23'd0) x[5] = 1'b1;
        end
        return x;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called one time unit after a rising edge with the DUT idle.
    task automatic run_op(input logic [31:0] x, input int lat, input bit noise);
        bit sp;
        logic [31:0] rad, res;
        model(x, sp, rad, res);
        fp_in = x;
        start = 1'b1;
        sq_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        step();
        start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        fp_in = $urandom();
        sq_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        exp_busy = 1'b1;
        if (sp) begin
            exp_ready = 1'b1;
            exp_sq_start = 1'b0;
            exp_fp = res;
            step();
        end else begin
            exp_sq_start = 1'b1;
            exp_ready = 1'b0;
            exp_num = rad;
            exp_num_chk = 1'b1;
            step();
            exp_sq_start = 1'b0;
            for (int i = 0; i < lat; i++) begin
                start = noise;
                fp_in = $urandom();
                sq_ready = 1'b0;
                step();
            end
            start = noise;
            sq_ready = 1'b1;
            sq_out = {16'($urandom()), isqrt(rad)};
            step();
            exp_ready = 1'b1;
            exp_fp = res;
            exp_num_chk = 1'b0;
            sq_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
        end
        exp_busy = 1'b0;
        exp_ready = 1'b0;
        exp_sq_start = 1'b0;
        start = 1'b0;
        sq_ready = 1'b0;
    endtask

    initial begin
        bit sp;
        logic [31:0] rad, res;

        // start is already high through reset so the first edge after release must accept it
        start = 1'b1;
        fp_in = 32'h40800000;
        #1 rst = 1'b0;

        model(32'h40800000, sp, rad, res);
        check("pin_4p0_rad", rad, 32'h40000000);
        check("pin_4p0_res", res, 32'h40000000);
        model(32'h40000000, sp, rad, res);
        check("pin_2p0_rad", rad, 32'h80000000);
        check("pin_2p0_res", res, 32'h3FB50400);
        check("pin_isqrt_2p0", 32'(isqrt(rad)), 32'h0000B504);
        model(32'h3F000000, sp, rad, res);
        check("pin_0p5_res", res, 32'h3F350400);
        model(32'h3E800000, sp, rad, res);
        check("pin_0p25_res", res, 32'h3F000000);
        model(32'hBF800000, sp, rad, res);
        check("pin_neg1_res", res, 32'h7FC00000);
        check("pin_neg1_special", 32'(sp), 32'd1);
        model(32'h00400000, sp, rad, res);
`ifdef SQRT_FP_DENORM_EN
        check("pin_denorm_res", res, 32'h1FB50400);
`else
        check("pin_denorm_res", res, 32'h00000000);
`endif

        exp_num = '0;
        exp_num_chk = 1'b1;
        cmp_en = 1'b1;
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fp_out", fp_out, 32'd0);
        check("rst_sq_num", sq_num, 32'd0);
        step();
        rst = 1'b1;
        exp_num_chk = 1'b0;

        run_op(32'h40800000, 2, 1'b0);
        run_op(32'h40000000, 0, 1'b0);
        run_op(32'h3F000000, 1, 1'b0);
        run_op(32'h3E800000, 4, 1'b0);
        run_op(32'hBF800000, 0, 1'b0);
        run_op(32'h7F800000, 0, 1'b0);
        run_op(32'h80000000, 0, 1'b0);
        run_op(32'h7FC00001, 0, 1'b0);
        run_op(32'h00400000, 1, 1'b0);
        run_op(32'h80400000, 1, 1'b0);
        run_op(32'h40000000, 3, 1'b1);

        // reset pulled low while waiting on the integer unit
        fp_in = 32'h40800000;
        start = 1'b1;
        step();
        start = 1'b0;
        exp_busy = 1'b1;
        exp_sq_start = 1'b1;
        exp_num = 32'h40000000;
        exp_num_chk = 1'b1;
        step();
        exp_sq_start = 1'b0;
        step();
        rst = 1'b0;
        exp_busy = 1'b0;
        exp_fp = '0;
        exp_num = '0;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_sq_start", 32'(sq_start), 32'd0);
        check("rst_mid_ready", 32'(ready), 32'd0);
        check("rst_mid_fp_out", fp_out, 32'd0);
        check("rst_mid_sq_num", sq_num, 32'd0);
        step();
        rst = 1'b1;
        exp_num_chk = 1'b0;
        sq_ready = 1'b1;
        sq_out = 32'h00008000;
        step();
        sq_ready = 1'b0;
        step();
        step();

        for (int n = 0; n < 300; n++)
            run_op(rand_operand(), $urandom_range(0, 4), 1'b1);

        step();
        step();
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
